// File: rtl/nonce_tx_pkg.sv
// Shared types and helpers for the nonce transmit arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nonce_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Upper nibble of the optional per-word header byte.
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width for a core count; a single core still gets a 1-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_tx_arbiter_if.sv
// Bundles the core request bus and the UART byte handshake of the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid held until req_ready; UART paced by uart_is_transmitting.
interface nonce_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4
);
  import nonce_tx_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*8*WORD_BYTES-1:0] req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            uart_transmit;
  logic [7:0]                      uart_tx_byte;
  logic                            uart_is_transmitting;
  logic                            busy;
  logic [ID_W-1:0]                 grant_id;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte, busy, grant_id
  );

  // Core array / UART side.
  modport slave (
    output req_valid, req_data, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte, busy, grant_id
  );

endinterface

// File: rtl/nonce_tx_arbiter_rr_arbiter.sv
// Round-robin pick of the first requester after rr_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter
  import nonce_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index,
  output logic               any
);

  // Scan rr_ptr+1 .. rr_ptr and keep the first hit.
  always_comb begin
    int idx;
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        index      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// Shares one UART between NUM_REQ cores; serialises the granted nonce MSB byte first.
// Latency: valid sampled at edge t gives req_ready and uart_transmit in cycle t+1.
// Backpressure: one word in flight; each byte waits for uart_is_transmitting low. NONCE_TX_HEADER_EN prepends {A, id}.
module nonce_tx_arbiter
  import nonce_tx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_BYTES = 4
) (
  input logic            clk,
  input logic            rst,
  nonce_tx_arbiter_if.master bus
);

  localparam int ID_W   = id_width(NUM_REQ);
  localparam int WORD_W = 8 * WORD_BYTES;
`ifdef NONCE_TX_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  // The shift register carries the header (if any) in front of the payload,
  // so every frame after the first is just "shift left a byte, send the top".
  localparam int SH_W = WORD_W + 8 * HDR_BYTES;
  localparam int BL_W = clog2(WORD_BYTES + 1);
  localparam logic [BL_W-1:0] BL_INIT = BL_W'(WORD_BYTES + HDR_BYTES - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [BL_W-1:0]     bytes_left_q, bytes_left_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                uart_transmit_q, uart_transmit_d;
  logic [7:0]          uart_tx_byte_q, uart_tx_byte_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [SH_W-1:0]     load_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .index  (arb_idx),
    .any    (arb_any)
  );

  // Frame image captured at grant: optional header followed by the winner's word.
  always_comb begin
`ifdef NONCE_TX_HEADER_EN
    logic [3:0] hdr_id;
    hdr_id = '0;
    hdr_id[ID_W-1:0] = arb_idx;
    load_word = {HDR_MAGIC, hdr_id, bus.req_data[arb_idx*WORD_W +: WORD_W]};
`else
    load_word = bus.req_data[arb_idx*WORD_W +: WORD_W];
`endif
  end

  // Grant / byte-pacing FSM; req_ready and uart_transmit are single-cycle pulses.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    shift_d         = shift_q;
    bytes_left_d    = bytes_left_q;
    req_ready_d     = '0;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte_q;
    busy_d          = busy_q;
    grant_id_d      = grant_id_q;
    case (state_q)
      IDLE: begin
        if (arb_any && !bus.uart_is_transmitting) begin
          shift_d         = load_word;
          uart_tx_byte_d  = load_word[SH_W-1 -: 8];
          uart_transmit_d = 1'b1;
          req_ready_d     = arb_grant;
          grant_id_d      = arb_idx;
          rr_ptr_d        = arb_idx;
          busy_d          = 1'b1;
          bytes_left_d    = BL_INIT;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        // The UART busy flag includes our own pulse, so skip the pulse cycle explicitly.
        if (!uart_transmit_q && !bus.uart_is_transmitting) begin
          if (bytes_left_q != '0) begin
            shift_d         = shift_q << 8;
            uart_tx_byte_d  = shift_d[SH_W-1 -: 8];
            uart_transmit_d = 1'b1;
            bytes_left_d    = bytes_left_q - 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; rr_ptr resets to the last core so core 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= ID_W'(NUM_REQ - 1);
      shift_q         <= '0;
      bytes_left_q    <= '0;
      req_ready_q     <= '0;
      uart_transmit_q <= 1'b0;
      uart_tx_byte_q  <= '0;
      busy_q          <= 1'b0;
      grant_id_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      shift_q         <= shift_d;
      bytes_left_q    <= bytes_left_d;
      req_ready_q     <= req_ready_d;
      uart_transmit_q <= uart_transmit_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
      busy_q          <= busy_d;
      grant_id_q      <= grant_id_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.uart_transmit = uart_transmit_q;
  assign bus.uart_tx_byte  = uart_tx_byte_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_id_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Bench for nonce_tx_arbiter: cycle table, directed corner sequences, random traffic.
// The UART is a small frame-timer model; cores are per-core word FIFOs.
// Expected grants follow the round-robin rule; expected line bytes come from the granted words.
module tb_nonce_tx_arbiter;

  localparam int N  = 4;
  localparam int WB = 4;
`ifdef NONCE_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB = WB + HDR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonce_tx_arbiter_if #(.NUM_REQ(N), .WORD_BYTES(WB)) bus ();

  nonce_tx_arbiter #(.NUM_REQ(N), .WORD_BYTES(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // UART model: busy for frame_len cycles after each transmit pulse, plus the pulse itself.
  logic [3:0] ucnt = 4'd0;
  int         frame_len = 0;
  logic       force_busy = 1'b0;

  always @(posedge clk) begin
    if (rst) ucnt <= 4'd0;
    else if (bus.uart_transmit) ucnt <= 4'(frame_len);
    else if (ucnt != 4'd0) ucnt <= ucnt - 4'd1;
  end

  assign bus.uart_is_transmitting = force_busy | bus.uart_transmit | (ucnt != 4'd0);

  int n_checks = 0;
  int n_errors = 0;

  // Core model and scoreboards.
  logic [31:0] wbuf [N][16];
  int          wcnt [N];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap_q [$];
  int          order_q [$];
  int          model_last = N - 1;
  bit          track = 1'b0;
  int          tx_seen = 0;
  int          overlap_cnt = 0;

  typedef struct {
    logic [3:0] v;
    logic       fb;
    logic [3:0] e_rdy;
    logic       e_tx;
    logic [7:0] e_byte;
    logic       e_busy;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word_bytes(input int id, input logic [31:0] w);
    if (HDR != 0) exp_q.push_back({4'hA, 4'(id)});
    for (int b = WB - 1; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic drive_valid();
    logic [N-1:0]    v;
    logic [N*32-1:0] d;
    v = '0;
    d = '0;
    for (int c = 0; c < N; c++) begin
      if (wcnt[c] != 0) begin
        v[c] = 1'b1;
        d[c*32 +: 32] = wbuf[c][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic add_word(input int c, input logic [31:0] w);
    if (wcnt[c] < 16) begin
      wbuf[c][wcnt[c]] = w;
      wcnt[c]++;
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int c = 0; c < N; c++) s += wcnt[c];
    return s;
  endfunction

  // Round-robin rule: first pending core after the last granted one.
  task automatic handle_grant();
    int g;
    logic [N-1:0] oh;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (model_last + k) % N;
      if (g < 0 && wcnt[j] != 0) g = j;
    end
    n_checks++;
    if (g < 0) begin
      n_errors++;
      $display("FAIL spurious_ack: req_ready=%b with no core pending", bus.req_ready);
    end else begin
      oh = '0;
      oh[g] = 1'b1;
      chk("ack_onehot", 32'(bus.req_ready), 32'(oh));
      chk("grant_id", 32'(bus.grant_id), 32'(g));
      push_word_bytes(g, wbuf[g][0]);
      order_q.push_back(g);
      model_last = g;
      for (int i = 0; i < 15; i++) wbuf[g][i] = wbuf[g][i+1];
      wcnt[g]--;
    end
  endtask

  // One clock: sample the line before the edge, step, then react to acks.
  task automatic cyc();
    if (bus.uart_transmit === 1'b1) begin
      if (ucnt != 4'd0) overlap_cnt++;
      cap_q.push_back(bus.uart_tx_byte);
      tx_seen++;
    end
    while (cap_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", cap_q.pop_front());
      end else begin
        chk("line_byte", 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (track && bus.req_ready != '0) handle_grant();
    if (track) drive_valid();
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((pending() != 0 || exp_q.size() != 0 || bus.busy !== 1'b0) && t < 3000) begin
      cyc();
      t++;
    end
    chk({nm, "_done_in_time"}, 32'(t < 3000), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < N; c++) wcnt[c] = 0;
    drive_valid();
    cyc();
    rst = 1'b0;
    model_last = N - 1;
    exp_q.delete();
    cap_q.delete();
    order_q.delete();
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({nm, "_transmit"}, 32'(bus.uart_transmit), 32'd0);
    chk({nm, "_tx_byte"}, 32'(bus.uart_tx_byte), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_grant_id"}, 32'(bus.grant_id), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bk [NB];
    int base;

    for (int c = 0; c < N; c++) wcnt[c] = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset values.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Cycle table: UART held busy with core 0 waiting, then released; DEADBEEF goes out.
    frame_len = 0;
    if (HDR != 0) bk[0] = 8'hA0;
    bk[HDR+0] = 8'hDE;
    bk[HDR+1] = 8'hAD;
    bk[HDR+2] = 8'hBE;
    bk[HDR+3] = 8'hEF;
    tbl.push_back('{v: 4'b0000, fb: 1'b1, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: 8'h00, e_busy: 1'b0});
    tbl.push_back('{v: 4'b0001, fb: 1'b1, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: 8'h00, e_busy: 1'b0});
    tbl.push_back('{v: 4'b0001, fb: 1'b1, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: 8'h00, e_busy: 1'b0});
    for (int k = 0; k < NB; k++) begin
      tbl.push_back('{v: (k == 0) ? 4'b0001 : 4'b0000, fb: 1'b0,
                      e_rdy: (k == 0) ? 4'b0001 : 4'b0000, e_tx: 1'b1, e_byte: bk[k], e_busy: 1'b1});
      tbl.push_back('{v: 4'b0000, fb: 1'b0, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: bk[k], e_busy: 1'b1});
    end
    tbl.push_back('{v: 4'b0000, fb: 1'b0, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: bk[NB-1], e_busy: 1'b0});
    tbl.push_back('{v: 4'b0000, fb: 1'b0, e_rdy: 4'b0000, e_tx: 1'b0, e_byte: bk[NB-1], e_busy: 1'b0});

    for (int k = 0; k < NB; k++) exp_q.push_back(bk[k]);
    for (int r = 0; r < tbl.size(); r++) begin
      bus.req_valid = tbl[r].v;
      bus.req_data  = {96'h0, 32'hDEADBEEF};
      force_busy    = tbl[r].fb;
      cyc();
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_transmit", r), 32'(bus.uart_transmit), 32'(tbl[r].e_tx));
      chk($sformatf("tbl%0d_tx_byte", r), 32'(bus.uart_tx_byte), 32'(tbl[r].e_byte));
      chk($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_grant_id", r), 32'(bus.grant_id), 32'd0);
    end
    cyc();
    chk("tbl_all_bytes_sent", 32'(exp_q.size()), 32'd0);

    // Cores 1 and 3 pending with last grant on core 1: core 3 must go first.
    track = 1'b1;
    model_last = 0;
    frame_len = 2;
    order_q.delete();
    add_word(1, 32'h1111_0001);
    drive_valid();
    drain("solo1");
    add_word(1, 32'h1111_0002);
    add_word(3, 32'h3333_0003);
    drive_valid();
    drain("pair13");
    chk("order13_len", 32'(order_q.size()), 32'd3);
    if (order_q.size() == 3) begin
      chk("order13_0", 32'(order_q[0]), 32'd1);
      chk("order13_1", 32'(order_q[1]), 32'd3);
      chk("order13_2", 32'(order_q[2]), 32'd1);
    end

    // Reset after the second byte goes out: outputs clear, full word resent.
    base = tx_seen;
    add_word(0, 32'h1122_3344);
    drive_valid();
    for (int t = 0; t < 500 && tx_seen < base + 2; t++) cyc();
    chk("midword_two_bytes_seen", 32'(tx_seen - base), 32'd2);
    rst = 1'b1;
    cyc();
    check_idle_outputs("midword_rst");
    rst = 1'b0;
    model_last = N - 1;
    exp_q.delete();
    cap_q.delete();
    order_q.delete();
    add_word(0, 32'h1122_3344);
    drive_valid();
    drain("resend");
    chk("resend_grants", 32'(order_q.size()), 32'd1);

    // All four cores pending, core 0 with two words: order 0,1,2,3,0.
    do_reset();
    frame_len = 1;
    add_word(0, 32'hA0A0_0000);
    add_word(0, 32'hA4A4_0004);
    add_word(1, 32'hA1A1_0001);
    add_word(2, 32'hA2A2_0002);
    add_word(3, 32'hA3A3_0003);
    drive_valid();
    drain("all4");
    chk("order_all4_len", 32'(order_q.size()), 32'd5);
    if (order_q.size() == 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("order_all4_%0d", i), 32'(order_q[i]), 32'(i % 4));
    end

    // Random traffic with random frame lengths and external UART use.
    for (int round = 0; round < 30; round++) begin
      frame_len = $urandom_range(0, 3);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        add_word($urandom_range(0, N - 1), $urandom);
      drive_valid();
      for (int t = 0; t < 20; t++) begin
        force_busy = ($urandom_range(0, 7) == 0);
        cyc();
      end
    end
    force_busy = 1'b0;
    drain("random");
    chk("uart_overlap", 32'(overlap_cnt), 32'd0);
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
